// File: rtl/gt_fetch_dm_subsystem_if.sv
`default_nettype none
// ============================================================================
// Module   : gt_fetch_dm_subsystem_if
// Brief    : Fetch-subsystem bundle: counter enable, memory write port and
//            fetch/status outputs.
// Revision : 1.0  initial release
// ============================================================================
interface gt_fetch_dm_subsystem_if #(
    parameter int MEM_LINES = 256
);
    localparam int MW = $clog2(MEM_LINES);

    logic           CTR_EN;
    logic           mem_we;
    logic [MW-1:0]  mem_waddr;
    logic [255:0]   mem_wdata;
    logic [31:0]    nextAddr;
    logic [31:0]    lineAddr;
    logic [255:0]   memData;
    logic [7:0]     dataReturn;
    logic           hit;
    logic           miss;

    // Environment side: drives enable and memory writes, observes the fetch.
    modport master (
        output CTR_EN, mem_we, mem_waddr, mem_wdata,
        input  nextAddr, lineAddr, memData, dataReturn, hit, miss
    );

    // Fetch subsystem side.
    modport slave (
        input  CTR_EN, mem_we, mem_waddr, mem_wdata,
        output nextAddr, lineAddr, memData, dataReturn, hit, miss
    );
endinterface
`default_nettype wire

// File: rtl/gt_fetch_dm_subsystem.sv
`default_nettype none
// ============================================================================
// Module   : gt_fetch_dm_subsystem
// Brief    : Byte program counter + direct-mapped I-cache (256-bit lines) +
//            line-wide main memory. Hits return one byte per cycle; a miss
//            reads the line, fills it, then retries.
// Revision : 1.0  initial release
// ============================================================================
module gt_fetch_dm_subsystem #(
    parameter int NUM_LINES = 32,
    parameter int MEM_LINES = 256
) (
    input  logic                          CLK,
    input  logic                          CLEAR_BAR,
    gt_fetch_dm_subsystem_if.slave        bus
);
    localparam int IW = $clog2(NUM_LINES);
    localparam int MW = $clog2(MEM_LINES);
    localparam int TW = 32 - 5 - IW;

    localparam logic [0:0] ST_LOOKUP = 1'b0;
    localparam logic [0:0] ST_FILL   = 1'b1;

    logic [0:0]           state;
    logic [0:0]           state_next;
    logic                 lookup_hit;

    logic [NUM_LINES-1:0] valid;
    logic [TW-1:0]        tag_mem  [NUM_LINES];
    logic [255:0]         line_mem [NUM_LINES];

    // Memory holds the difference from the power-up pattern, so an all-zero
    // array represents the "each byte equals its own address" image without
    // needing a reset or a load sequence.
    logic [255:0]         mem_delta [MEM_LINES] = '{default: '0};

    logic [4:0]           offset;
    logic [IW-1:0]        index;
    logic [TW-1:0]        tag;
    logic [MW-1:0]        mem_line;

    assign offset   = bus.nextAddr[4:0];
    assign index    = bus.nextAddr[5+IW-1:5];
    assign tag      = bus.nextAddr[31:5+IW];
    assign mem_line = bus.nextAddr[5+MW-1:5];

    // Power-up line image: byte k of line L is (32*L + k) mod 256.
    function automatic logic [255:0] default_line(input logic [MW-1:0] l);
        logic [255:0] d;
        d = '0;
        for (int k = 0; k < 32; k++) begin
            d[8*k +: 8] = {l[2:0], 5'(k)};
        end
        return d;
    endfunction

    // State register.
    always_ff @(posedge CLK or negedge CLEAR_BAR) begin
        if (!CLEAR_BAR) state <= ST_LOOKUP;
        else            state <= state_next;
    end

    // Next state: a miss always costs exactly one FILL cycle.
    always_comb begin
        state_next = state;
        case (state)
            ST_LOOKUP: if (!lookup_hit) state_next = ST_FILL;
            ST_FILL:   state_next = ST_LOOKUP;
            default:   state_next = ST_LOOKUP;
        endcase
    end

    // Outputs: hit only in LOOKUP on a valid line with matching tag.
    always_comb begin
        lookup_hit = 1'b0;
        if (state == ST_LOOKUP) lookup_hit = valid[index] && (tag_mem[index] == tag);
        bus.hit  = lookup_hit;
        bus.miss = ~lookup_hit;
    end

    // Counter, request/return registers and valid bits.
    always_ff @(posedge CLK or negedge CLEAR_BAR) begin
        if (!CLEAR_BAR) begin
            bus.nextAddr   <= '0;
            bus.lineAddr   <= '0;
            bus.memData    <= '0;
            bus.dataReturn <= '0;
            valid          <= '0;
        end else if (state == ST_FILL) begin
            valid[index] <= 1'b1;
        end else if (lookup_hit) begin
            bus.dataReturn <= line_mem[index][{offset, 3'b000} +: 8];
            if (bus.CTR_EN) bus.nextAddr <= bus.nextAddr + 32'd1;
        end else begin
            bus.lineAddr <= {bus.nextAddr[31:5], 5'b00000};
            bus.memData  <= mem_delta[mem_line] ^ default_line(mem_line);
        end
    end

    // Cache line/tag storage; only meaningful where valid is set.
    always_ff @(posedge CLK) begin
        if (state == ST_FILL) begin
            tag_mem[index]  <= tag;
            line_mem[index] <= bus.memData;
        end
    end

    // Memory write port, independent of reset and FSM state.
    always_ff @(posedge CLK) begin
        if (bus.mem_we) mem_delta[bus.mem_waddr] <= bus.mem_wdata ^ default_line(bus.mem_waddr);
    end
endmodule
`default_nettype wire

// File: tb/tb_gt_fetch_dm_subsystem.sv
`default_nettype none
// ============================================================================
// Module   : tb_gt_fetch_dm_subsystem
// Brief    : Randomized scoreboard bench with a byte-level reference model.
// Revision : 1.0  initial release
// ============================================================================
module tb_gt_fetch_dm_subsystem;
    localparam int NL = 32;
    localparam int ML = 256;

    logic clk;
    logic clear_bar;

    gt_fetch_dm_subsystem_if #(.MEM_LINES(ML)) bus_if ();

    gt_fetch_dm_subsystem #(.NUM_LINES(NL), .MEM_LINES(ML)) dut (
        .CLK       (clk),
        .CLEAR_BAR (clear_bar),
        .bus       (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0]  pc;
        logic [31:0]  la;
        logic [255:0] md;
        logic [7:0]   dr;
        logic         h;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Reference model: byte-addressed memory, cache remembers which line
    // number it holds plus a snapshot of that line's bytes.
    logic [7:0]   m_mem   [ML*32];
    bit           m_valid [NL];
    int unsigned  m_lnum  [NL];
    logic [255:0] m_cdata [NL];
    logic [31:0]  m_pc, m_la;
    logic [255:0] m_md;
    logic [7:0]   m_dr;
    bit           m_filling;

    function automatic logic [255:0] m_read_line(input int unsigned ln);
        logic [255:0] b;
        for (int k = 0; k < 32; k++) b[8*k +: 8] = m_mem[(ln % ML)*32 + k];
        return b;
    endfunction

    function automatic bit m_hit();
        int unsigned ln = m_pc >> 5;
        return !m_filling && m_valid[ln % NL] && (m_lnum[ln % NL] == ln);
    endfunction

    task automatic m_reset();
        m_pc = 0; m_la = 0; m_md = '0; m_dr = 0; m_filling = 0;
        for (int i = 0; i < NL; i++) m_valid[i] = 0;
    endtask

    // One clock cycle: drive at the falling edge, record what the DUT must
    // show during this cycle, then advance the model across the rising edge.
    task automatic step(input bit en, input bit rst_now, input bit we,
                        input int unsigned wline, input logic [255:0] wd);
        exp_t e;
        int unsigned ln;
        @(negedge clk);
        bus_if.CTR_EN    = en;
        bus_if.mem_we    = we;
        bus_if.mem_waddr = 8'(wline);
        bus_if.mem_wdata = wd;
        clear_bar        = !rst_now;
        if (rst_now) m_reset();
        e.pc = m_pc; e.la = m_la; e.md = m_md; e.dr = m_dr;
        e.h  = rst_now ? 1'b0 : m_hit();
        q.push_back(e);
        if (!rst_now) begin
            ln = m_pc >> 5;
            if (m_filling) begin
                m_valid[ln % NL] = 1; m_lnum[ln % NL] = ln; m_cdata[ln % NL] = m_md;
                m_filling = 0;
            end else if (e.h) begin
                m_dr = m_cdata[ln % NL][8*m_pc[4:0] +: 8];
                if (en) m_pc = m_pc + 1;
            end else begin
                m_la = m_pc & ~32'h1F;
                m_md = m_read_line(ln);
                m_filling = 1;
            end
        end
        if (we) for (int k = 0; k < 32; k++) m_mem[(wline % ML)*32 + k] = wd[8*k +: 8];
    endtask

    task automatic run(input bit en);
        step(en, 0, 0, 0, '0);
    endtask

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Monitor: compares every recorded expectation against the DUT mid-cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            while (q.size() > 0) begin
                e = q.pop_front();
                check("nextAddr",   256'(bus_if.nextAddr),   256'(e.pc));
                check("lineAddr",   256'(bus_if.lineAddr),   256'(e.la));
                check("memData",    bus_if.memData,          e.md);
                check("dataReturn", 256'(bus_if.dataReturn), 256'(e.dr));
                check("hit",        256'(bus_if.hit),        256'(e.h));
                check("miss",       256'(bus_if.miss),       256'(!e.h));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int guard;
        for (int a = 0; a < ML*32; a++) m_mem[a] = 8'(a);
        m_reset();
        clear_bar        = 1'b0;
        bus_if.CTR_EN    = 1'b0;
        bus_if.mem_we    = 1'b0;
        bus_if.mem_waddr = '0;
        bus_if.mem_wdata = '0;

        // Reset held three cycles.
        repeat (3) step(1, 1, 0, 0, '0);

        // Cold sequential fetch until pc 5 is hitting, then hold.
        guard = 0;
        while (!(m_pc == 32'h5 && m_hit()) && guard < 100) begin run(1); guard++; end
        repeat (6) run(0);

        // Continue across many lines and into the index-0 conflict at 0x400.
        while (m_pc < 32'h420) run(1);

        // Random enable and memory writes aimed near the fetch line, long
        // enough to pass 8 KiB and exercise memory aliasing.
        for (int i = 0; i < 12000; i++) begin
            bit we = ($urandom_range(0, 7) == 0);
            int unsigned wl = ($urandom_range(0, 3) == 0) ? $urandom_range(0, ML-1)
                                                          : ((m_pc >> 5) + $urandom_range(0, 2)) % ML;
            step($urandom_range(0, 7) != 0, 0, we, wl, {8{$urandom()}});
        end

        // Memory write during reset: line 0 becomes all 0xAA.
        step(1, 1, 1, 0, {32{8'hAA}});
        step(1, 1, 0, 0, '0);
        repeat (40) run(1);

        // Reset asserted during the FILL of line 0, then refetch.
        step(1, 1, 0, 0, '0);
        run(1);
        step(1, 1, 0, 0, '0);
        repeat (6) run(1);

        @(negedge clk);
        #3;
        n_cmp++;
        if (q.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
`default_nettype wire
